// File: rtl/fmap_raddr_pkg.sv
// Shared types for the feature-map read-address generator: scan modes, FSM states, bank slots.
// No logic, no latency.
// No flow control.
package fmap_raddr_pkg;

    // Scan mode as presented on cfg_mode; codes 2/3 are reserved and behave as NORMAL
    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'd0,
        MODE_UPSAMPLE = 2'd1
    } mode_t;

    // Scan controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Slot of each bank address inside the packed raddr bus {a3,a2,a1,a0}
    localparam int BANK0     = 0;
    localparam int BANK1     = 1;
    localparam int BANK2     = 2;
    localparam int BANK3     = 3;
    localparam int NUM_BANKS = 4;

endpackage

// File: rtl/raddr_delay_line.sv
// Fixed-depth shift register carrying {vld, raddr} for write-back/residual reuse.
// Latency: DEPTH enabled cycles from din to dout.
// Backpressure: en low freezes every stage, so held words are neither duplicated nor dropped.
module raddr_delay_line #(
    parameter int DEPTH = 5,
    parameter int W     = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [DEPTH];

    // Shift one stage per enabled cycle; reset clears contents including the valid bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/fmap_raddr_gen.sv
// Raster-scan read-address generator for 2x2-interleaved A/B feature banks, plus weight/bias counters.
// Latency: raddr 1 cycle after the row/col counters; raddr_dly a further DLY non-stalled cycles.
// Backpressure: stall freezes counters, raddr, delay line and drain count. Optional: RADDR_CLAMP_EN.
module fmap_raddr_gen #(
    parameter int ADDR_W    = 16,
    parameter int ROW_W     = 9,
    parameter int COL_W     = 10,
    parameter int DLY       = 5,
    parameter int WB_ADDR_W = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ROW_W-1:0]      cfg_rows,
    input  logic [COL_W-1:0]      cfg_cols,
    input  logic [ADDR_W-1:0]     cfg_stride,
    input  logic [1:0]            cfg_mode,
    input  logic                  stall,
    input  logic                  layer_end,
    input  logic                  wb_clr,
    output logic                  busy,
    output logic                  done,
    output logic [ROW_W-1:0]      row,
    output logic [COL_W-1:0]      col,
    output logic [4*ADDR_W-1:0]   raddr,
    output logic                  raddr_vld,
    output logic [4*ADDR_W-1:0]   raddr_dly,
    output logic                  raddr_dly_vld,
    output logic [WB_ADDR_W-1:0]  weight_addr,
    output logic [WB_ADDR_W-1:0]  bias_addr
);
    import fmap_raddr_pkg::*;

    localparam int DC_W = $clog2(DLY + 2);

    state_t              state;
    logic [ROW_W-1:0]    rows_q;
    logic [COL_W-1:0]    cols_q;
    logic [ADDR_W-1:0]   stride_q;
    logic                ups_q;
    logic [DC_W-1:0]     drain_cnt;
`ifdef RADDR_CLAMP_EN
    logic [ROW_W-1:0]    last_r;
    logic [COL_W-1:0]    last_c;
`endif

    logic [ROW_W-1:0]    src_r;
    logic [COL_W-1:0]    src_c;
    logic [ADDR_W-1:0]   nxt_r, nxt_c, hi_r, hi_c, lo_r, lo_c, base_hi, base_lo;
    logic [4*ADDR_W-1:0] addr_nxt;
    logic [4*ADDR_W:0]   dly_dout;

    // Scan controller: latches the job at start, walks the raster, then drains the delay line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            row       <= '0;
            col       <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            stride_q  <= '0;
            ups_q     <= 1'b0;
            drain_cnt <= '0;
`ifdef RADDR_CLAMP_EN
            last_r    <= '0;
            last_c    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rows_q    <= cfg_rows;
                        cols_q    <= cfg_cols;
                        stride_q  <= cfg_stride;
                        ups_q     <= (mode_t'(cfg_mode) == MODE_UPSAMPLE);
                        row       <= '0;
                        col       <= '0;
                        drain_cnt <= '0;
                        busy      <= 1'b1;
`ifdef RADDR_CLAMP_EN
                        last_r <= (mode_t'(cfg_mode) == MODE_UPSAMPLE) ?
                                  ((cfg_rows - ROW_W'(1)) >> 1) : (cfg_rows - ROW_W'(1));
                        last_c <= (mode_t'(cfg_mode) == MODE_UPSAMPLE) ?
                                  ((cfg_cols - COL_W'(1)) >> 1) : (cfg_cols - COL_W'(1));
`endif
                        // An empty map issues nothing but still reports completion
                        state <= (cfg_rows == '0 || cfg_cols == '0) ? ST_DRAIN : ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!stall) begin
                        if (col == cols_q - COL_W'(1)) begin
                            // Counters park on the last pixel once it has been issued
                            if (row == rows_q - ROW_W'(1)) begin
                                state <= ST_DRAIN;
                            end else begin
                                col <= '0;
                                row <= row + ROW_W'(1);
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // One cycle to register the last raddr, DLY more to push it out of the delay line
                    if (!stall) begin
                        if (drain_cnt == DC_W'(DLY)) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + DC_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bank address arithmetic for the pixel the counters currently point at
    always_comb begin
        src_r = ups_q ? (row >> 1) : row;
        src_c = ups_q ? (col >> 1) : col;
        nxt_r = ADDR_W'(src_r) + ADDR_W'(1);
        nxt_c = ADDR_W'(src_c) + ADDR_W'(1);
`ifdef RADDR_CLAMP_EN
        // Replicate the edge row/column instead of reading past the source map
        if (nxt_r > ADDR_W'(last_r)) nxt_r = ADDR_W'(last_r);
        if (nxt_c > ADDR_W'(last_c)) nxt_c = ADDR_W'(last_c);
`endif
        hi_r    = nxt_r >> 1;
        hi_c    = nxt_c >> 1;
        lo_r    = ADDR_W'(src_r) >> 1;
        lo_c    = ADDR_W'(src_c) >> 1;
        base_hi = hi_r * stride_q;
        base_lo = lo_r * stride_q;
        addr_nxt = '0;
        addr_nxt[BANK0*ADDR_W +: ADDR_W] = hi_c + base_hi;
        addr_nxt[BANK1*ADDR_W +: ADDR_W] = lo_c + base_hi;
        addr_nxt[BANK2*ADDR_W +: ADDR_W] = hi_c + base_lo;
        addr_nxt[BANK3*ADDR_W +: ADDR_W] = lo_c + base_lo;
    end

    // Register addresses while scanning; a stalled cycle holds both data and valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raddr     <= '0;
            raddr_vld <= 1'b0;
        end else if (!stall) begin
            raddr_vld <= (state == ST_SCAN);
            if (state == ST_SCAN) raddr <= addr_nxt;
        end
    end

    raddr_delay_line #(
        .DEPTH (DLY),
        .W     (4*ADDR_W + 1)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!stall),
        .din   ({raddr_vld, raddr}),
        .dout  (dly_dout)
    );

    assign raddr_dly_vld = dly_dout[4*ADDR_W];
    assign raddr_dly     = dly_dout[4*ADDR_W-1:0];

    // Weight/bias layer counters run independently of the scan; clear beats advance
    always_ff @(posedge clk) begin
        if (!rst_n || wb_clr) begin
            weight_addr <= '0;
            bias_addr   <= '0;
        end else if (layer_end) begin
            weight_addr <= weight_addr + WB_ADDR_W'(1);
            bias_addr   <= bias_addr + WB_ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_fmap_raddr_gen.sv
// Self-checking bench for fmap_raddr_gen: table of scan jobs with a scoreboard, plus hand sequences.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
// Honours RADDR_CLAMP_EN for the expected edge addresses.
module tb_fmap_raddr_gen;

`ifdef RADDR_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  cfg_rows = '0;
    logic [9:0]  cfg_cols = '0;
    logic [15:0] cfg_stride = '0;
    logic [1:0]  cfg_mode = '0;
    logic        stall = 1'b0;
    logic        layer_end = 1'b0;
    logic        wb_clr = 1'b0;
    logic        busy, done, raddr_vld, raddr_dly_vld;
    logic [8:0]  row;
    logic [9:0]  col;
    logic [63:0] raddr, raddr_dly;
    logic [8:0]  weight_addr, bias_addr;

    fmap_raddr_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .cfg_stride(cfg_stride), .cfg_mode(cfg_mode), .stall(stall), .layer_end(layer_end),
        .wb_clr(wb_clr), .busy(busy), .done(done), .row(row), .col(col), .raddr(raddr),
        .raddr_vld(raddr_vld), .raddr_dly(raddr_dly), .raddr_dly_vld(raddr_dly_vld),
        .weight_addr(weight_addr), .bias_addr(bias_addr)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc = 0, vld_cnt = 0, done_cnt = 0, done_cyc = 0, last_dly_cyc = 0;
    bit mon_en = 1'b0;
    logic [63:0] last_raddr = '0;
    logic [63:0] exp_q[$];
    logic [63:0] dly_q[$];

    typedef struct {
        int          rows, cols, stride, mode, pct;
        bit          poke;
        int          exp_n;
        logic [63:0] exp_last;
        bit          chk_last;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)", name, act, act, exp, exp);
    endtask

    task automatic fail_msg(input string name, input string msg);
        chk_cnt++;
        $display("FAIL %s: %s", name, msg);
    endtask

    function automatic logic [63:0] pk(input int a3, input int a2, input int a1, input int a0);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    // Reference address model for one pixel
    function automatic logic [63:0] model(input int prow, input int pcol, input int rows,
                                          input int cols, input int stride, input int mode);
        int r, c, r1, c1, lr, lc;
        r  = (mode == 1) ? prow >> 1 : prow;
        c  = (mode == 1) ? pcol >> 1 : pcol;
        lr = (mode == 1) ? (rows - 1) >> 1 : rows - 1;
        lc = (mode == 1) ? (cols - 1) >> 1 : cols - 1;
        r1 = r + 1;
        c1 = c + 1;
        if (CLAMP && r1 > lr) r1 = lr;
        if (CLAMP && c1 > lc) c1 = lc;
        return pk((c >> 1) + (r >> 1) * stride, (c1 >> 1) + (r >> 1) * stride,
                  (c >> 1) + (r1 >> 1) * stride, (c1 >> 1) + (r1 >> 1) * stride);
    endfunction

    // Scoreboard: compare each accepted raddr with the model and each raddr_dly with the raddr history
    always @(negedge clk) begin
        logic [63:0] e;
        cyc = cyc + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (mon_en) begin
            if (raddr_vld && !stall) begin
                vld_cnt = vld_cnt + 1;
                last_raddr = raddr;
                dly_q.push_back(raddr);
                if (exp_q.size() == 0) fail_msg("raddr_extra", $sformatf("unexpected raddr 0x%h", raddr));
                else begin
                    e = exp_q.pop_front();
                    check("raddr", raddr, e);
                end
            end
            if (raddr_dly_vld && !stall) begin
                last_dly_cyc = cyc;
                if (dly_q.size() == 0) fail_msg("raddr_dly_extra", $sformatf("unexpected raddr_dly 0x%h", raddr_dly));
                else begin
                    e = dly_q.pop_front();
                    check("raddr_dly", raddr_dly, e);
                end
            end
        end
    end

    task automatic run_scan(input vec_t v);
        int n, budget;
        vld_cnt = 0; done_cnt = 0; done_cyc = 0; last_dly_cyc = 0; last_raddr = '0;
        exp_q.delete();
        dly_q.delete();
        for (int r = 0; r < v.rows; r++)
            for (int c = 0; c < v.cols; c++)
                exp_q.push_back(model(r, c, v.rows, v.cols, v.stride, v.mode));
        @(posedge clk); #1;
        cfg_rows = 9'(v.rows); cfg_cols = 10'(v.cols); cfg_stride = 16'(v.stride);
        cfg_mode = 2'(v.mode); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("row_first", 64'(row), 64'd0);
        check("col_first", 64'(col), 64'd0);
        budget = v.rows * v.cols * 10 + 100;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            stall = (v.pct > 0) && ($urandom_range(99) < 32'(v.pct));
            if (v.poke && n == 5) begin
                cfg_rows = 9'd2; cfg_cols = 10'd2; cfg_stride = 16'd7; cfg_mode = 2'd1; start = 1'b1;
            end else start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        stall = 1'b0;
        start = 1'b0;
        if (done_cnt == 0) fail_msg("done_timeout", $sformatf("no done within %0d cycles", budget));
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("pixel_count", 64'(vld_cnt), 64'(v.exp_n));
        check("exp_left", 64'(exp_q.size()), 64'd0);
        check("dly_left", 64'(dly_q.size()), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        if (v.chk_last) check("last_raddr", last_raddr, v.exp_last);
        if (v.pct == 0 && v.exp_n > 0) check("done_after_dly", 64'(done_cyc), 64'(last_dly_cyc + 1));
    endtask

    task automatic check_zero(input string p);
        check({p, "_busy"}, 64'(busy), 64'd0);
        check({p, "_done"}, 64'(done), 64'd0);
        check({p, "_row"}, 64'(row), 64'd0);
        check({p, "_col"}, 64'(col), 64'd0);
        check({p, "_raddr"}, raddr, 64'd0);
        check({p, "_raddr_vld"}, 64'(raddr_vld), 64'd0);
        check({p, "_raddr_dly"}, raddr_dly, 64'd0);
        check({p, "_raddr_dly_vld"}, 64'(raddr_dly_vld), 64'd0);
        check({p, "_weight"}, 64'(weight_addr), 64'd0);
        check({p, "_bias"}, 64'(bias_addr), 64'd0);
    endtask

    initial begin
        bit found;
        int done_base;
        //        rows cols stride mode pct poke n  last (a3,a2,a1,a0)                                          chk
        vecs[0] = '{4, 6, 321,   0, 0,  0, 24, CLAMP ? pk(323,323,323,323) : pk(323,324,644,645), 1};
        vecs[1] = '{4, 4, 321,   1, 0,  0, 16, CLAMP ? pk(0,0,0,0) : pk(0,1,321,322), 1};
        vecs[2] = '{1, 1, 321,   0, 0,  0, 1,  pk(0,0,0,0), 1};
        vecs[3] = '{2, 3, 1000,  3, 0,  0, 6,  CLAMP ? pk(1,1,1,1) : pk(1,1,1001,1001), 1};
        vecs[4] = '{4, 6, 40000, 0, 0,  0, 24, CLAMP ? pk(40002,40002,40002,40002) : pk(40002,40003,14466,14467), 1};
        vecs[5] = '{0, 5, 321,   0, 0,  0, 0,  64'd0, 0};
        vecs[6] = '{3, 0, 321,   0, 0,  0, 0,  64'd0, 0};
        vecs[7] = '{8, 8, 321,   0, 30, 0, 64, CLAMP ? pk(966,966,966,966) : pk(966,967,1287,1288), 1};
        vecs[8] = '{4, 6, 321,   0, 0,  1, 24, CLAMP ? pk(323,323,323,323) : pk(323,324,644,645), 1};

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Weight/bias counters: three advances, clear-beats-advance, wrap
        layer_end = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        layer_end = 1'b0;
        check("weight_after_3", 64'(weight_addr), 64'd3);
        check("bias_after_3", 64'(bias_addr), 64'd3);
        wb_clr = 1'b1; layer_end = 1'b1;
        @(posedge clk); #1;
        wb_clr = 1'b0; layer_end = 1'b0;
        check("weight_clr_wins", 64'(weight_addr), 64'd0);
        check("bias_clr_wins", 64'(bias_addr), 64'd0);
        layer_end = 1'b1;
        repeat (513) @(posedge clk);
        #1;
        layer_end = 1'b0;
        check("weight_wrap", 64'(weight_addr), 64'd1);
        check("bias_wrap", 64'(bias_addr), 64'd1);

        mon_en = 1'b1;
        for (int i = 0; i < 9; i++) run_scan(vecs[i]);

        // Reset in the middle of a scan: immediate return to reset state, no done
        mon_en = 1'b0;
        @(posedge clk); #1;
        cfg_rows = 9'd4; cfg_cols = 10'd6; cfg_stride = 16'd321; cfg_mode = 2'd0; start = 1'b1;
        layer_end = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        layer_end = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if (row == 9'd2 && col == 10'd3) found = 1'b1;
        end
        if (!found) fail_msg("mid_scan_reach", "scan never reached (2,3)");
        done_base = done_cnt;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_zero("rst_mid");
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("no_done_after_rst", 64'(done_cnt), 64'(done_base));
        check("idle_after_rst", 64'(busy), 64'd0);
        mon_en = 1'b1;
        run_scan(vecs[0]);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
